// File: rtl/kolibri_pkg.sv
// Shared definitions for the SD-card SPI master: register map, CTRL/STATUS
// bit positions, divider width and the shifter state encoding.
package kolibri_pkg;

    localparam int DIV_W = 8;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int CTRL_SEL0 = 0;
    localparam int CTRL_SEL1 = 1;
    localparam int STAT_OVR  = 6;
    localparam int STAT_BUSY = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_bus_sync.sv
// Brings the asynchronous CPU chip select into the MHZ48 domain, holds the
// address/direction/data seen during the E cycle and emits exactly one
// write or read strobe per bus access, on the cycle the synchronised select rises.
module spi_bus_sync (
    input  logic       clk,
    input  logic       rstN,
    input  logic       nSel,
    input  logic       rdNwr,
    input  logic [1:0] addrIn,
    input  logic [7:0] dataIn,
    output logic       wrStb,
    output logic       rdStb,
    output logic [1:0] regAddr,
    output logic [7:0] regData
);

    logic s1;
    logic s2;
    logic capRw;

    // Two-flop synchroniser plus rising-edge detect that produces the commit strobes
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            wrStb <= 1'b0;
            rdStb <= 1'b0;
        end else begin
            s1    <= nSel;
            s2    <= s1;
            wrStb <= s1 & ~s2 & ~capRw;
            rdStb <= s1 & ~s2 & capRw;
        end
    end

    // Track the bus fields while the access is still active; they freeze once s1 goes high
    always_ff @(posedge clk) begin
        if (!s1) begin
            capRw   <= rdNwr;
            regAddr <= addrIn;
            regData <= dataIn;
        end
    end

endmodule

// File: rtl/spi_sd_master.sv
// Byte-wide polled SPI master (mode 0, MSB first) for two SD card slots.
// Optional feature macro: SPI_AUTOREAD_EN -- a DATA read while idle launches
// an 8'hFF transfer so sector reads can be streamed with one load per byte.
module spi_sd_master
    import kolibri_pkg::*;
#(
    parameter int DIV_RESET = 59
) (
    input  logic       MHZ48,
    input  logic       nRES,
    input  logic       nSPICS,
    input  logic       RW,
    input  logic [1:0] A,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       nSD0,
    output logic       nSD1,
    output logic       MOSI,
    output logic       SCLK,
    input  logic       MISO
);

`ifdef SPI_AUTOREAD_EN
    localparam bit AUTOREAD = 1'b1;
`else
    localparam bit AUTOREAD = 1'b0;
`endif

    logic             wrStb;
    logic             rdStb;
    logic [1:0]       regAddr;
    logic [7:0]       regData;

    spi_state_t       state;
    logic [7:0]       shiftReg;
    logic [7:0]       rxByte;
    logic [DIV_W-1:0] divReg;
    logic [DIV_W-1:0] cnt;
    logic [2:0]       bitCnt;
    logic             busy;
    logic             ovr;
    logic             sel0;
    logic             sel1;
    logic             sclkR;
    logic             mosiR;

    logic             dataWr;
    logic             autoRd;
    logic             startXfer;
    logic [7:0]       txByte;

    spi_bus_sync uBusSync (
        .clk    (MHZ48),
        .rstN   (nRES),
        .nSel   (nSPICS),
        .rdNwr  (RW),
        .addrIn (A),
        .dataIn (DIN),
        .wrStb  (wrStb),
        .rdStb  (rdStb),
        .regAddr(regAddr),
        .regData(regData)
    );

    assign dataWr    = wrStb && (regAddr == REG_DATA);
    assign autoRd    = AUTOREAD && rdStb && (regAddr == REG_DATA);
    assign startXfer = (dataWr || autoRd) && !busy;
    assign txByte    = dataWr ? regData : 8'hFF;

    // Control registers: chip selects, divider and the sticky overrun flag
    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            sel0   <= 1'b0;
            sel1   <= 1'b0;
            divReg <= DIV_W'(DIV_RESET);
            ovr    <= 1'b0;
        end else if (wrStb) begin
            case (regAddr)
                REG_CTRL: begin
                    sel0 <= regData[CTRL_SEL0];
                    sel1 <= regData[CTRL_SEL1];
                    ovr  <= 1'b0;
                end
                REG_DIV:  divReg <= regData;
                REG_DATA: if (busy) ovr <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Shifter FSM: IDLE -> LOW -> HIGH -> (LOW | IDLE), each half period divReg+1 cycles
    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            state    <= IDLE;
            sclkR    <= 1'b0;
            mosiR    <= 1'b1;
            shiftReg <= 8'hFF;
            rxByte   <= 8'hFF;
            cnt      <= '0;
            bitCnt   <= 3'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclkR <= 1'b0;
                    mosiR <= 1'b1;
                    if (startXfer) begin
                        shiftReg <= txByte;
                        mosiR    <= txByte[7];
                        bitCnt   <= 3'd0;
                        cnt      <= divReg;
                        busy     <= 1'b1;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == '0) begin
                        sclkR    <= 1'b1;
                        shiftReg <= {shiftReg[6:0], MISO};
                        cnt      <= divReg;
                        state    <= HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        sclkR <= 1'b0;
                        if (bitCnt == 3'd7) begin
                            rxByte <= shiftReg;
                            busy   <= 1'b0;
                            mosiR  <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            mosiR  <= shiftReg[7];
                            bitCnt <= bitCnt + 3'd1;
                            cnt    <= divReg;
                            state  <= LOW;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU read mux follows the live address so data is valid during the E cycle
    always_comb begin
        DOUT = 8'h00;
        case (A)
            REG_DATA: DOUT = rxByte;
            REG_CTRL: DOUT = {busy, ovr, 4'b0000, sel1, sel0};
            REG_DIV:  DOUT = divReg;
            default:  DOUT = 8'h00;
        endcase
    end

    assign DOE  = ~nSPICS & RW;
    assign nSD0 = ~sel0;
    assign nSD1 = ~sel1;
    assign SCLK = sclkR;
    assign MOSI = mosiR;

endmodule

// File: tb/tb_spi_sd_master.sv
// Directed bench for spi_sd_master with a byte-serving SD card MISO model.
module tb_spi_sd_master;

    logic       MHZ48 = 1'b0;
    logic       nRES;
    logic       nSPICS;
    logic       RW;
    logic [1:0] A;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;
    logic       nSD0;
    logic       nSD1;
    logic       MOSI;
    logic       SCLK;
    logic       MISO;

    int checks = 0;
    int errors = 0;

    // card model: byte served MSB first, advancing after every SCLK rise
    logic [7:0] misoByte = 8'hFF;
    int         riseBase = 0;
    int         riseCnt  = 0;
    logic [7:0] mosiCap  = 8'h00;
    time        firstRiseT = 0;
    time        lastRiseT  = 0;
    time        lastFallT  = 0;
    logic [2:0] misoIdx;

    assign misoIdx = 3'(riseCnt - riseBase);
    assign MISO    = misoByte[~misoIdx];

    spi_sd_master #(.DIV_RESET(59)) dut (
        .MHZ48 (MHZ48),
        .nRES  (nRES),
        .nSPICS(nSPICS),
        .RW    (RW),
        .A     (A),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .DOE   (DOE),
        .nSD0  (nSD0),
        .nSD1  (nSD1),
        .MOSI  (MOSI),
        .SCLK  (SCLK),
        .MISO  (MISO)
    );

    always #10 MHZ48 = ~MHZ48;

    always @(posedge SCLK) begin
        if (riseCnt == riseBase) firstRiseT <= $time;
        lastRiseT <= $time;
        mosiCap   <= {mosiCap[6:0], MOSI};
        riseCnt   <= riseCnt + 1;
    end

    always @(negedge SCLK) lastFallT <= $time;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
        @(posedge MHZ48); #1;
        A = a; RW = 1'b0; DIN = d; nSPICS = 1'b0;
        repeat (4) @(posedge MHZ48);
        #1 nSPICS = 1'b1;
        repeat (4) @(posedge MHZ48);
        #1 RW = 1'b1;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [7:0] d, output logic doe);
        @(posedge MHZ48); #1;
        A = a; RW = 1'b1; nSPICS = 1'b0;
        repeat (4) @(posedge MHZ48);
        #1 d = DOUT; doe = DOE;
        nSPICS = 1'b1;
        repeat (4) @(posedge MHZ48);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        logic [7:0] st;
        logic       doe;
        st = 8'h80;
        for (int i = 0; i < 300; i++) begin
            busRead(2'd1, st, doe);
            if (!st[7]) break;
        end
        checkVal(tag, {31'd0, st[7]}, 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       doe;

        nRES = 1'b0; nSPICS = 1'b1; RW = 1'b1; A = 2'd0; DIN = 8'h00;
        repeat (3) @(posedge MHZ48);
        #1;
        checkVal("rstNsd0", {31'd0, nSD0}, 32'd1);
        checkVal("rstNsd1", {31'd0, nSD1}, 32'd1);
        checkVal("rstSclk", {31'd0, SCLK}, 32'd0);
        checkVal("rstMosi", {31'd0, MOSI}, 32'd1);
        checkVal("rstDoe",  {31'd0, DOE},  32'd0);
        nRES = 1'b1;
        busRead(2'd1, rd, doe);
        checkVal("rstCtrl", {24'd0, rd}, 32'h00);
        checkVal("readDoe", {31'd0, doe}, 32'd1);
        busRead(2'd2, rd, doe);
        checkVal("rstDiv", {24'd0, rd}, 32'd59);
        busRead(2'd0, rd, doe);
        checkVal("rstRx", {24'd0, rd}, 32'hFF);
        busRead(2'd3, rd, doe);
        checkVal("reg3", {24'd0, rd}, 32'h00);

        // fastest divider: 8'hA5 out, 8'h3C in
        busWrite(2'd2, 8'h00);
        busRead(2'd2, rd, doe);
        checkVal("div0Read", {24'd0, rd}, 32'h00);
        busWrite(2'd1, 8'h01);
        checkVal("sel0Nsd0", {31'd0, nSD0}, 32'd0);
        checkVal("sel0Nsd1", {31'd0, nSD1}, 32'd1);
        misoByte = 8'h3C;
        riseBase = riseCnt;
        busWrite(2'd0, 8'hA5);
        repeat (30) @(posedge MHZ48);
        #1;
        checkVal("div0Rises", riseCnt - riseBase, 32'd8);
        checkVal("div0Mosi", {24'd0, mosiCap}, 32'hA5);
        checkVal("div0Period", 32'((lastRiseT - firstRiseT) / 20), 32'd14);
        checkVal("div0Byte", 32'((lastFallT - firstRiseT) / 20), 32'd15);
        busRead(2'd0, rd, doe);
        checkVal("div0Rx", {24'd0, rd}, 32'h3C);
        busRead(2'd1, rd, doe);
        checkVal("div0Ctrl", {24'd0, rd}, 32'h01);

        // init-speed divider: 8'h00 out, 8'h5A in
        busWrite(2'd2, 8'd59);
        misoByte = 8'h5A;
        riseBase = riseCnt;
        busWrite(2'd0, 8'h00);
        busRead(2'd1, rd, doe);
        checkVal("div59Busy", {31'd0, rd[7]}, 32'd1);
        busRead(2'd0, rd, doe);
        checkVal("div59RxHeld", {24'd0, rd}, 32'h3C);
        waitIdle("div59Idle");
        checkVal("div59Rises", riseCnt - riseBase, 32'd8);
        checkVal("div59Mosi", {24'd0, mosiCap}, 32'h00);
        checkVal("div59Period", 32'((lastRiseT - firstRiseT) / 20), 32'd840);
        checkVal("div59Byte", 32'((lastFallT - firstRiseT) / 20), 32'd900);
        busRead(2'd0, rd, doe);
        checkVal("div59Rx", {24'd0, rd}, 32'h5A);

        // DATA read side effect depends on the build option
        misoByte = 8'h96;
        riseBase = riseCnt;
        busRead(2'd0, rd, doe);
        checkVal("autoRdRet", {24'd0, rd}, 32'h5A);
`ifdef SPI_AUTOREAD_EN
        busRead(2'd1, rd, doe);
        checkVal("autoRdBusy", {31'd0, rd[7]}, 32'd1);
        waitIdle("autoRdIdle");
        checkVal("autoRdRises", riseCnt - riseBase, 32'd8);
        checkVal("autoRdMosi", {24'd0, mosiCap}, 32'hFF);
        busRead(2'd1, rd, doe);
        checkVal("autoRdOvr", {31'd0, rd[6]}, 32'd0);
        misoByte = 8'hFF;
        busRead(2'd0, rd, doe);
        checkVal("autoRdRx", {24'd0, rd}, 32'h96);
        waitIdle("autoRdIdle2");
`else
        repeat (200) @(posedge MHZ48);
        #1;
        checkVal("noAutoRises", riseCnt - riseBase, 32'd0);
        busRead(2'd1, rd, doe);
        checkVal("noAutoCtrl", {24'd0, rd}, 32'h01);
`endif

        // overrun: second write while busy is dropped
        riseBase = riseCnt;
        busWrite(2'd0, 8'h11);
        busWrite(2'd0, 8'h22);
        waitIdle("ovrIdle");
        checkVal("ovrRises", riseCnt - riseBase, 32'd8);
        checkVal("ovrMosi", {24'd0, mosiCap}, 32'h11);
        busRead(2'd1, rd, doe);
        checkVal("ovrCtrl", {24'd0, rd}, 32'h41);
        busWrite(2'd1, 8'h00);
        busRead(2'd1, rd, doe);
        checkVal("ovrClear", {24'd0, rd}, 32'h00);
        checkVal("deselNsd0", {31'd0, nSD0}, 32'd1);
        checkVal("deselNsd1", {31'd0, nSD1}, 32'd1);

        // both cards selected, then reset mid-byte
        busWrite(2'd1, 8'h03);
        checkVal("bothNsd0", {31'd0, nSD0}, 32'd0);
        checkVal("bothNsd1", {31'd0, nSD1}, 32'd0);
        riseBase = riseCnt;
        busWrite(2'd0, 8'hF0);
        for (int i = 0; i < 3000; i++) begin
            if (riseCnt - riseBase >= 3) break;
            @(posedge MHZ48);
        end
        checkVal("midRises", riseCnt - riseBase, 32'd3);
        @(posedge MHZ48);
        #2;
        checkVal("midSclkPre", {31'd0, SCLK}, 32'd1);
        nRES = 1'b0;
        #1;
        checkVal("midSclk", {31'd0, SCLK}, 32'd0);
        checkVal("midMosi", {31'd0, MOSI}, 32'd1);
        checkVal("midNsd0", {31'd0, nSD0}, 32'd1);
        checkVal("midNsd1", {31'd0, nSD1}, 32'd1);
        repeat (2) @(posedge MHZ48);
        #1 nRES = 1'b1;
        busRead(2'd1, rd, doe);
        checkVal("midCtrl", {24'd0, rd}, 32'h00);
        busRead(2'd0, rd, doe);
        checkVal("midRx", {24'd0, rd}, 32'hFF);
        busRead(2'd2, rd, doe);
        checkVal("midDiv", {24'd0, rd}, 32'd59);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
